multicycle_control_unit: RTL and testbench

Multi-cycle successor to the single-cycle opcode decoder for the MIPS-style datapath. It sequences each instruction through FETCH, DECODE, EXEC, MEM and WB states and issues per-state datapath strobes. It handshakes with instruction/data memory over `mem_ready`, with a wait-timeout, and supports a pipeline-style `stall` hold. It sits between the instruction register and the datapath muxes, register file, ALU control and memory port.

---
 rtl/multicycle_control_unit_if.sv | 42 ++++
 rtl/multicycle_control_unit.sv | 209 ++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_unit_if.sv
// Bundle between the multi-cycle control unit and the datapath/memory side.
//   opcode, stall, mem_ready : datapath -> control unit
//   strobes, selects, state, pulses : control unit -> datapath
// modport master : control unit side
// modport slave  : datapath / memory side
interface multicycle_control_unit_if #(
  parameter int unsigned OPCODE_W = 3
);
  logic [OPCODE_W-1:0] opcode;
  logic                stall;
  logic                mem_ready;
  logic                pc_write;
  logic                ir_write;
  logic                mem_read;
  logic                mem_write;
  logic                reg_write;
  logic [1:0]          reg_dst;
  logic [1:0]          mem_to_reg;
  logic [1:0]          alu_op;
  logic                alu_src;
  logic                branch;
  logic                jump;
  logic                sign_or_zero;
  logic [2:0]          state;
  logic                instr_done;
  logic                illegal_op;
  logic                mem_timeout;

  modport master (
    input  opcode, stall, mem_ready,
    output pc_write, ir_write, mem_read, mem_write, reg_write,
           reg_dst, mem_to_reg, alu_op, alu_src, branch, jump, sign_or_zero,
           state, instr_done, illegal_op, mem_timeout
  );

  modport slave (
    output opcode, stall, mem_ready,
    input  pc_write, ir_write, mem_read, mem_write, reg_write,
           reg_dst, mem_to_reg, alu_op, alu_src, branch, jump, sign_or_zero,
           state, instr_done, illegal_op, mem_timeout
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS-style control unit: sequences FETCH/DECODE/EXEC/MEM/WB and
// decodes per-state datapath strobes, with a memory wait timeout and stall hold.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : multicycle_control_unit_if.master (opcode/stall/mem_ready in,
//           strobes, selects, state and event pulses out)
// Outputs are a combinational decode of the state, the latched opcode, the wait
// counter and the current stall/mem_ready/reset inputs, so a strobe lands in the
// same cycle as the handshake that qualifies it.
module multicycle_control_unit #(
  parameter int unsigned OPCODE_W    = 3,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input logic                        clk,
  input logic                        reset,
  multicycle_control_unit_if.master  bus
);
  localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  localparam logic [2:0] OP_R    = 3'd0;
  localparam logic [2:0] OP_SLTI = 3'd1;
  localparam logic [2:0] OP_J    = 3'd2;
  localparam logic [2:0] OP_JAL  = 3'd3;
  localparam logic [2:0] OP_LW   = 3'd4;
  localparam logic [2:0] OP_SW   = 3'd5;
  localparam logic [2:0] OP_BEQ  = 3'd6;
  localparam logic [2:0] OP_ADDI = 3'd7;

  state_t              state_q;
  state_t              state_d;
  logic [2:0]          op_q;
  logic [CNT_W-1:0]    wait_q;
  logic [OPCODE_W-1:0] opcode_c;
  logic                op_legal_c;
  logic                mem_phase_c;
  logic                timeout_c;
  logic                wait_inc_c;

  assign opcode_c = bus.opcode;

  // Any opcode bit above [2:0] set makes the instruction illegal.
  assign op_legal_c  = (opcode_c >> 3) == '0;
  assign mem_phase_c = (state_q == FETCH) || (state_q == MEM);
  assign timeout_c   = mem_phase_c && !bus.mem_ready && (wait_q == CNT_W'(MEM_TIMEOUT));
  assign wait_inc_c  = mem_phase_c && !bus.mem_ready && !timeout_c;

  // State, latched opcode and wait counter; stall freezes all three.
  // The counter clears whenever the current state is left, so it is zero on
  // every entry to FETCH or MEM (including the re-fetch after a timeout).
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      op_q    <= 3'd0;
      wait_q  <= '0;
    end else if (!bus.stall) begin
      state_q <= state_d;
      if (state_q == DECODE) op_q <= opcode_c[2:0];
      if (wait_inc_c) wait_q <= wait_q + CNT_W'(1);
      else            wait_q <= '0;
    end
  end

  // Next state and output decode.
  always_comb begin
    state_d          = state_q;
    bus.pc_write     = 1'b0;
    bus.ir_write     = 1'b0;
    bus.mem_read     = 1'b0;
    bus.mem_write    = 1'b0;
    bus.reg_write    = 1'b0;
    bus.reg_dst      = 2'b00;
    bus.mem_to_reg   = 2'b00;
    bus.alu_op       = 2'b00;
    bus.alu_src      = 1'b0;
    bus.branch       = 1'b0;
    bus.jump         = 1'b0;
    bus.sign_or_zero = 1'b1;
    bus.state        = state_q;
    bus.instr_done   = 1'b0;
    bus.illegal_op   = 1'b0;
    bus.mem_timeout  = 1'b0;

    case (state_q)
      FETCH: begin
        if (timeout_c) begin
          bus.mem_timeout = 1'b1;
          state_d         = FETCH;
        end else begin
          bus.mem_read = 1'b1;
          if (bus.mem_ready) begin
            bus.ir_write = 1'b1;
            bus.pc_write = 1'b1;
            state_d      = DECODE;
          end
        end
      end
      DECODE: begin
        if (!op_legal_c) begin
          bus.illegal_op = 1'b1;
          bus.instr_done = 1'b1;
          state_d        = FETCH;
        end else if (opcode_c[2:0] == OP_J) begin
          bus.jump       = 1'b1;
          bus.pc_write   = 1'b1;
          bus.instr_done = 1'b1;
          state_d        = FETCH;
        end else if (opcode_c[2:0] == OP_JAL) begin
          bus.jump       = 1'b1;
          bus.pc_write   = 1'b1;
          bus.reg_write  = 1'b1;
          bus.reg_dst    = 2'b10;
          bus.mem_to_reg = 2'b10;
          bus.instr_done = 1'b1;
          state_d        = FETCH;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        case (op_q)
          OP_R: begin
            bus.alu_op = 2'b00;
            state_d    = WB;
          end
          OP_SLTI: begin
            bus.alu_op       = 2'b10;
            bus.alu_src      = 1'b1;
            bus.sign_or_zero = 1'b0;
            state_d          = WB;
          end
          OP_ADDI: begin
            bus.alu_op  = 2'b11;
            bus.alu_src = 1'b1;
            state_d     = WB;
          end
          OP_LW, OP_SW: begin
            bus.alu_op  = 2'b11;
            bus.alu_src = 1'b1;
            state_d     = MEM;
          end
          OP_BEQ: begin
            bus.alu_op     = 2'b01;
            bus.branch     = 1'b1;
            bus.instr_done = 1'b1;
            state_d        = FETCH;
          end
          default: state_d = FETCH;
        endcase
      end
      MEM: begin
        if (timeout_c) begin
          bus.mem_timeout = 1'b1;
          state_d         = FETCH;
        end else if (op_q == OP_LW) begin
          bus.mem_read = 1'b1;
          if (bus.mem_ready) state_d = WB;
        end else begin
          bus.mem_write = 1'b1;
          if (bus.mem_ready) begin
            bus.instr_done = 1'b1;
            state_d        = FETCH;
          end
        end
      end
      WB: begin
        bus.reg_write  = 1'b1;
        bus.instr_done = 1'b1;
        bus.reg_dst    = (op_q == OP_R)  ? 2'b01 : 2'b00;
        bus.mem_to_reg = (op_q == OP_LW) ? 2'b01 : 2'b00;
        state_d        = FETCH;
      end
      default: state_d = FETCH;
    endcase

    // Stall and reset both suppress strobes and event pulses.
    if (bus.stall || reset) begin
      state_d         = state_q;
      bus.pc_write    = 1'b0;
      bus.ir_write    = 1'b0;
      bus.mem_read    = 1'b0;
      bus.mem_write   = 1'b0;
      bus.reg_write   = 1'b0;
      bus.instr_done  = 1'b0;
      bus.illegal_op  = 1'b0;
      bus.mem_timeout = 1'b0;
    end

    // Reset cycle shows the idle FETCH decode regardless of the held state.
    if (reset) begin
      bus.reg_dst      = 2'b00;
      bus.mem_to_reg   = 2'b00;
      bus.alu_op       = 2'b00;
      bus.alu_src      = 1'b0;
      bus.branch       = 1'b0;
      bus.jump         = 1'b0;
      bus.sign_or_zero = 1'b1;
      bus.state        = 3'd0;
    end
  end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit (OPCODE_W=4, MEM_TIMEOUT=15).
// A stimulus process drives one input vector per cycle, asks a phase-plan
// reference model for the expected outputs and queues them; a monitor pops and
// compares on the falling edge.
module tb_multicycle_control_unit;
  localparam int unsigned OPW = 4;
  localparam int unsigned TO  = 15;

  localparam int PH_F = 0;
  localparam int PH_D = 1;
  localparam int PH_E = 2;
  localparam int PH_M = 3;
  localparam int PH_W = 4;

  typedef struct packed {
    logic [2:0] state;
    logic       pc_write;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic [1:0] alu_op;
    logic       alu_src;
    logic       branch;
    logic       jump;
    logic       sign_or_zero;
    logic       instr_done;
    logic       illegal_op;
    logic       mem_timeout;
  } out_t;

  typedef struct {
    int   cyc;
    out_t o;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  multicycle_control_unit_if #(.OPCODE_W(OPW)) bus ();

  multicycle_control_unit #(.OPCODE_W(OPW), .MEM_TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  exp_t       exp_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc_no = 0;
  int         exp_done = 0;
  int         act_done = 0;

  // Reference model: the instruction is a plan of phases still to run.
  int         plan[$];
  int         wait_cnt = 0;
  logic [2:0] mop = 3'd0;

  task automatic model_step(input logic rst, input logic [OPW-1:0] op,
                            input logic stl, input logic rdy, output out_t e);
    int ph;
    bit mem_ph;
    bit to_hit;
    bit done;
    e = '0;
    e.sign_or_zero = 1'b1;
    if (rst) begin
      plan.delete();
      plan.push_back(PH_F);
      plan.push_back(PH_D);
      wait_cnt = 0;
      mop = 3'd0;
    end else begin
      ph     = plan[0];
      e.state = 3'(ph);
      mem_ph = (ph == PH_F) || (ph == PH_M);
      to_hit = mem_ph && !rdy && (wait_cnt == int'(TO));
      done   = 1'b0;
      case (ph)
        PH_F: begin
          if (to_hit) e.mem_timeout = 1'b1;
          else begin
            e.mem_read = 1'b1;
            if (rdy) begin e.ir_write = 1'b1; e.pc_write = 1'b1; end
          end
        end
        PH_D: begin
          if (op[OPW-1:3] != '0) begin
            e.illegal_op = 1'b1;
            done = 1'b1;
          end else if (op[2:0] == 3'd2) begin
            e.jump = 1'b1; e.pc_write = 1'b1; done = 1'b1;
          end else if (op[2:0] == 3'd3) begin
            e.jump = 1'b1; e.pc_write = 1'b1; e.reg_write = 1'b1;
            e.reg_dst = 2'd2; e.mem_to_reg = 2'd2; done = 1'b1;
          end
        end
        PH_E: begin
          case (mop)
            3'd0: e.alu_op = 2'd0;
            3'd1: begin e.alu_op = 2'd2; e.alu_src = 1'b1; e.sign_or_zero = 1'b0; end
            3'd6: begin e.alu_op = 2'd1; e.branch = 1'b1; done = 1'b1; end
            default: begin e.alu_op = 2'd3; e.alu_src = 1'b1; end
          endcase
        end
        PH_M: begin
          if (to_hit) e.mem_timeout = 1'b1;
          else if (mop == 3'd4) e.mem_read = 1'b1;
          else begin
            e.mem_write = 1'b1;
            if (rdy) done = 1'b1;
          end
        end
        default: begin
          e.reg_write = 1'b1;
          done = 1'b1;
          e.reg_dst    = (mop == 3'd0) ? 2'd1 : 2'd0;
          e.mem_to_reg = (mop == 3'd4) ? 2'd1 : 2'd0;
        end
      endcase
      e.instr_done = done;
      if (stl) begin
        e.pc_write = 1'b0; e.ir_write = 1'b0; e.mem_read = 1'b0;
        e.mem_write = 1'b0; e.reg_write = 1'b0; e.instr_done = 1'b0;
        e.illegal_op = 1'b0; e.mem_timeout = 1'b0;
      end else begin
        if (done) exp_done++;
        if (to_hit) begin
          plan.delete();
          wait_cnt = 0;
        end else if (mem_ph && !rdy) begin
          wait_cnt++;
        end else begin
          void'(plan.pop_front());
          wait_cnt = 0;
          if (ph == PH_D && op[OPW-1:3] == '0) begin
            mop = op[2:0];
            case (op[2:0])
              3'd0, 3'd1, 3'd7: begin plan.push_back(PH_E); plan.push_back(PH_W); end
              3'd4: begin plan.push_back(PH_E); plan.push_back(PH_M); plan.push_back(PH_W); end
              3'd5: begin plan.push_back(PH_E); plan.push_back(PH_M); end
              3'd6: plan.push_back(PH_E);
              default: ;
            endcase
          end
        end
        if (plan.size() == 0) begin
          plan.push_back(PH_F);
          plan.push_back(PH_D);
        end
      end
    end
  endtask

  task automatic cyc(input logic rst, input logic [OPW-1:0] op, input logic stl, input logic rdy);
    exp_t it;
    @(posedge clk);
    #1;
    reset         = rst;
    bus.opcode    = op;
    bus.stall     = stl;
    bus.mem_ready = rdy;
    model_step(rst, op, stl, rdy, it.o);
    it.cyc = cyc_no;
    cyc_no++;
    exp_q.push_back(it);
  endtask

  task automatic run(input int n, input logic [OPW-1:0] op, input logic stl, input logic rdy);
    repeat (n) cyc(1'b0, op, stl, rdy);
  endtask

  // Monitor: compare the full output vector against the queued expectation.
  always @(negedge clk) begin
    exp_t it;
    out_t act;
    if (exp_q.size() != 0) begin
      it  = exp_q.pop_front();
      act = {bus.state, bus.pc_write, bus.ir_write, bus.mem_read, bus.mem_write,
             bus.reg_write, bus.reg_dst, bus.mem_to_reg, bus.alu_op, bus.alu_src,
             bus.branch, bus.jump, bus.sign_or_zero, bus.instr_done,
             bus.illegal_op, bus.mem_timeout};
      n_cmp++;
      if (act !== it.o) begin
        n_bad++;
        $display("FAIL outputs cycle %0d: got state=%0d vec=%h, expected state=%0d vec=%h",
                 it.cyc, act.state, act, it.o.state, it.o);
      end
      if (bus.instr_done === 1'b1) act_done++;
    end
  end

  initial begin
    int p_rdy;
    bus.opcode    = '0;
    bus.stall     = 1'b0;
    bus.mem_ready = 1'b0;

    // Reset, then R-type with memory always ready.
    cyc(1'b1, 4'd0, 1'b0, 1'b1);
    cyc(1'b1, 4'd0, 1'b0, 1'b1);
    run(4, 4'd0, 1'b0, 1'b1);
    // lw with three MEM wait cycles.
    run(3, 4'd4, 1'b0, 1'b1);
    run(3, 4'd4, 1'b0, 1'b0);
    run(2, 4'd4, 1'b0, 1'b1);
    // jal, j, beq, slti.
    run(2, 4'd3, 1'b0, 1'b1);
    run(2, 4'd2, 1'b0, 1'b1);
    run(3, 4'd6, 1'b0, 1'b1);
    run(4, 4'd1, 1'b0, 1'b1);
    // FETCH timeout on the 16th waiting cycle, then a fresh fetch.
    run(16, 4'd0, 1'b0, 1'b0);
    run(1, 4'd0, 1'b0, 1'b0);
    run(4, 4'd0, 1'b0, 1'b1);
    // Illegal opcode 1001.
    run(2, 4'b1001, 1'b0, 1'b1);
    // addi stalled two cycles in WB.
    run(3, 4'd7, 1'b0, 1'b1);
    run(2, 4'd7, 1'b1, 1'b1);
    run(1, 4'd7, 1'b0, 1'b1);
    // sw interrupted by reset while waiting in MEM.
    run(3, 4'd5, 1'b0, 1'b1);
    run(2, 4'd5, 1'b0, 1'b0);
    cyc(1'b1, 4'd5, 1'b0, 1'b0);
    run(4, 4'd5, 1'b0, 1'b1);
    // lw aborted by MEM timeout.
    run(3, 4'd4, 1'b0, 1'b1);
    run(16, 4'd4, 1'b0, 1'b0);
    // Stall at the timeout limit overrides the abort; ready then completes.
    run(15, 4'd0, 1'b0, 1'b0);
    run(2, 4'd0, 1'b1, 1'b0);
    run(4, 4'd0, 1'b0, 1'b1);

    // Random traffic with varying memory readiness.
    for (int blk = 0; blk < 12; blk++) begin
      p_rdy = (blk % 3 == 0) ? 30 : ((blk % 3 == 1) ? 75 : 95);
      for (int i = 0; i < 50; i++) begin
        cyc(($urandom % 100) == 0,
            (($urandom % 8) == 0) ? OPW'($urandom % 16) : OPW'($urandom % 8),
            ($urandom % 8) == 0,
            int'($urandom % 100) < p_rdy);
      end
    end

    @(posedge clk);
    @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    n_cmp++;
    if (act_done != exp_done) begin
      n_bad++;
      $display("FAIL done_count: got %0d instr_done pulses, expected %0d", act_done, exp_done);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
